// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//
// Shares one single-port instruction/data memory between the fetch stage and
// the memory stage of the pipeline. In IDLE one request is granted per cycle.
// Data wins by default, but fetch is forced to win after STARVE_LIMIT
// consecutive lost arbitrations. A granted read moves the FSM to WAIT for
// READ_LATENCY cycles. The response is then routed back to its owner as a
// single-cycle pulse, with mem_data_out passed straight through.
// Writes complete on accept.
//
// Ports:
//   clock, reset          - single clock, synchronous active-high reset
//   f_req_*               - fetch read request (valid/addr) and accept (ready)
//   f_flush               - discard the outstanding fetch response
//   f_resp_valid/_data    - fetch response pulse
//   m_req_*               - data request (valid/write/addr/wdata/size) and ready
//   m_resp_valid/_data    - load response pulse
//   mem_*                 - memory port: strobe, write flag, address, write
//                           data and size, plus the read data input
module unified_mem_arbiter #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        f_req_valid,
    input  logic [31:0] f_req_addr,
    output logic        f_req_ready,
    input  logic        f_flush,
    output logic        f_resp_valid,
    output logic [31:0] f_resp_data,

    input  logic        m_req_valid,
    input  logic        m_req_write,
    input  logic [31:0] m_req_addr,
    input  logic [31:0] m_req_wdata,
    input  logic [1:0]  m_req_size,
    output logic        m_req_ready,
    output logic        m_resp_valid,
    output logic [31:0] m_resp_data,

    output logic        mem_enable,
    output logic        mem_read_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_access_size,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    localparam logic [2:0] LatLimit   = 3'(READ_LATENCY);
    localparam logic [3:0] StarveLim  = 4'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic        owner_fetch_q, owner_fetch_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic        drop_q, drop_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;

    logic        data_win;
    logic        fetch_win;
    logic        starve_hit;

    always_comb begin
        state_d         = state_q;
        owner_fetch_d   = owner_fetch_q;
        lat_cnt_d       = lat_cnt_q;
        drop_d          = drop_q;
        starve_cnt_d    = starve_cnt_q;

        data_win        = 1'b0;
        fetch_win       = 1'b0;
        starve_hit      = 1'b0;

        f_req_ready     = 1'b0;
        f_resp_valid    = 1'b0;
        f_resp_data     = 32'h0;
        m_req_ready     = 1'b0;
        m_resp_valid    = 1'b0;
        m_resp_data     = 32'h0;
        mem_enable      = 1'b0;
        mem_read_write  = 1'b0;
        mem_addr        = 32'h0;
        mem_wdata       = 32'h0;
        mem_access_size = 2'b00;

        case (state_q)
            StIdle: begin
                starve_hit = f_req_valid && (starve_cnt_q == StarveLim);
                if (m_req_valid && !starve_hit) begin
                    data_win = 1'b1;
                end else if (f_req_valid) begin
                    fetch_win = 1'b1;
                end

                if (data_win) begin
                    m_req_ready     = 1'b1;
                    mem_enable      = 1'b1;
                    mem_read_write  = m_req_write;
                    mem_addr        = m_req_addr;
                    mem_wdata       = m_req_wdata;
                    mem_access_size = m_req_size;
                    // Stores finish on accept; only loads wait for data.
                    if (!m_req_write) begin
                        state_d       = StWait;
                        owner_fetch_d = 1'b0;
                        lat_cnt_d     = 3'd1;
                        drop_d        = 1'b0;
                    end
                end else if (fetch_win) begin
                    f_req_ready     = 1'b1;
                    mem_enable      = 1'b1;
                    mem_addr        = f_req_addr;
                    mem_access_size = 2'b10;
                    state_d         = StWait;
                    owner_fetch_d   = 1'b1;
                    lat_cnt_d       = 3'd1;
                    // A branch resolving in the accept cycle already kills this fetch.
                    drop_d          = f_flush;
                end

                // Count only fetches that lost to data; anything else restarts the count.
                if (f_req_valid && data_win) begin
                    if (starve_cnt_q != 4'hF) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else begin
                    starve_cnt_d = 4'd0;
                end
            end

            StWait: begin
                lat_cnt_d = lat_cnt_q + 3'd1;
                if (owner_fetch_q && f_flush) begin
                    drop_d = 1'b1;
                end
                if (lat_cnt_q == LatLimit) begin
                    state_d   = StIdle;
                    lat_cnt_d = 3'd0;
                    drop_d    = 1'b0;
                    if (owner_fetch_q) begin
                        // A flush landing on the response cycle also discards it.
                        f_resp_valid = !(drop_q || f_flush);
                        f_resp_data  = f_resp_valid ? mem_data_out : 32'h0;
                    end else begin
                        m_resp_valid = 1'b1;
                        m_resp_data  = mem_data_out;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Keep the whole interface quiet while reset is held.
        if (reset) begin
            f_req_ready     = 1'b0;
            f_resp_valid    = 1'b0;
            f_resp_data     = 32'h0;
            m_req_ready     = 1'b0;
            m_resp_valid    = 1'b0;
            m_resp_data     = 32'h0;
            mem_enable      = 1'b0;
            mem_read_write  = 1'b0;
            mem_addr        = 32'h0;
            mem_wdata       = 32'h0;
            mem_access_size = 2'b00;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            owner_fetch_q <= 1'b0;
            lat_cnt_q     <= 3'd0;
            drop_q        <= 1'b0;
            starve_cnt_q  <= 4'd0;
        end else begin
            state_q       <= state_d;
            owner_fetch_q <= owner_fetch_d;
            lat_cnt_q     <= lat_cnt_d;
            drop_q        <= drop_d;
            starve_cnt_q  <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.
// The model tracks the cycle number at which the outstanding read returns.
module tb_unified_mem_arbiter;

    localparam int unsigned RL = 3;
    localparam int unsigned SL = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        f_req_valid;
    logic [31:0] f_req_addr;
    logic        f_req_ready;
    logic        f_flush;
    logic        f_resp_valid;
    logic [31:0] f_resp_data;
    logic        m_req_valid;
    logic        m_req_write;
    logic [31:0] m_req_addr;
    logic [31:0] m_req_wdata;
    logic [1:0]  m_req_size;
    logic        m_req_ready;
    logic        m_resp_valid;
    logic [31:0] m_resp_data;
    logic        mem_enable;
    logic        mem_read_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_data_out;

    always #5 clock = ~clock;

    unified_mem_arbiter #(
        .READ_LATENCY(RL),
        .STARVE_LIMIT(SL)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .f_req_valid     (f_req_valid),
        .f_req_addr      (f_req_addr),
        .f_req_ready     (f_req_ready),
        .f_flush         (f_flush),
        .f_resp_valid    (f_resp_valid),
        .f_resp_data     (f_resp_data),
        .m_req_valid     (m_req_valid),
        .m_req_write     (m_req_write),
        .m_req_addr      (m_req_addr),
        .m_req_wdata     (m_req_wdata),
        .m_req_size      (m_req_size),
        .m_req_ready     (m_req_ready),
        .m_resp_valid    (m_resp_valid),
        .m_resp_data     (m_resp_data),
        .mem_enable      (mem_enable),
        .mem_read_write  (mem_read_write),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_access_size (mem_access_size),
        .mem_data_out    (mem_data_out)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: a pending read is described by its return cycle.
    int cyc = 0;
    int starve = 0;
    bit pend = 1'b0;
    bit own_f = 1'b0;
    bit drop = 1'b0;
    int resp_cyc = 0;
    bit exp_f_acc;
    bit exp_m_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs mid-cycle, then advance the model.
    task automatic tick();
        logic        e_fr, e_mr, e_fv, e_mv, e_en, e_rw;
        logic [31:0] e_fd, e_md, e_addr, e_wd;
        logic [1:0]  e_sz;
        bit          dw, fw;
        #4;
        e_fr = 0; e_mr = 0; e_fv = 0; e_mv = 0; e_en = 0; e_rw = 0;
        e_fd = 0; e_md = 0; e_addr = 0; e_wd = 0; e_sz = 0;
        dw = 0; fw = 0;
        if (!reset) begin
            if (!pend) begin
                dw = m_req_valid && !(f_req_valid && starve == SL);
                fw = !dw && f_req_valid;
                if (dw) begin
                    e_mr = 1; e_en = 1; e_rw = m_req_write;
                    e_addr = m_req_addr; e_wd = m_req_wdata; e_sz = m_req_size;
                end else if (fw) begin
                    e_fr = 1; e_en = 1; e_addr = f_req_addr; e_sz = 2'b10;
                end
            end else if (cyc == resp_cyc) begin
                if (own_f) begin
                    e_fv = !(drop || f_flush);
                    e_fd = e_fv ? mem_data_out : 32'h0;
                end else begin
                    e_mv = 1; e_md = mem_data_out;
                end
            end
        end
        exp_f_acc = fw;
        exp_m_acc = dw;
        chk("f_req_ready",     {31'h0, f_req_ready},     {31'h0, e_fr});
        chk("m_req_ready",     {31'h0, m_req_ready},     {31'h0, e_mr});
        chk("f_resp_valid",    {31'h0, f_resp_valid},    {31'h0, e_fv});
        chk("f_resp_data",     f_resp_data,              e_fd);
        chk("m_resp_valid",    {31'h0, m_resp_valid},    {31'h0, e_mv});
        chk("m_resp_data",     m_resp_data,              e_md);
        chk("mem_enable",      {31'h0, mem_enable},      {31'h0, e_en});
        chk("mem_read_write",  {31'h0, mem_read_write},  {31'h0, e_rw});
        chk("mem_addr",        mem_addr,                 e_addr);
        chk("mem_wdata",       mem_wdata,                e_wd);
        chk("mem_access_size", {30'h0, mem_access_size}, {30'h0, e_sz});
        @(posedge clock);
        if (reset) begin
            pend = 0; drop = 0; starve = 0;
        end else if (!pend) begin
            if (f_req_valid && dw) starve = (starve < 15) ? starve + 1 : 15;
            else starve = 0;
            if ((dw && !m_req_write) || fw) begin
                pend = 1; resp_cyc = cyc + int'(RL); own_f = fw; drop = fw && f_flush;
            end
        end else begin
            if (own_f && f_flush) drop = 1;
            if (cyc == resp_cyc) pend = 0;
        end
        cyc++;
        #1;
    endtask

    initial begin
        reset = 1; f_req_valid = 0; f_req_addr = 0; f_flush = 0;
        m_req_valid = 0; m_req_write = 0; m_req_addr = 0; m_req_wdata = 0; m_req_size = 0;
        mem_data_out = 32'hA5A5_5A5A;
        @(posedge clock); #1;

        // Reset held, then released with no requests.
        tick(); tick();
        reset = 0;
        tick(); tick();

        // Fetch only; response after RL cycles, next accept right after.
        f_req_valid = 1; f_req_addr = 32'h0100_0000;
        tick();
        f_req_valid = 0;
        tick(); tick();
        mem_data_out = 32'h0000_0013;
        tick();
        f_req_valid = 1; f_req_addr = 32'h0100_0004;
        tick();
        f_req_valid = 0;
        repeat (3) tick();

        // Store then back-to-back load.
        m_req_valid = 1; m_req_write = 1; m_req_addr = 32'h0100_0100;
        m_req_wdata = 32'hDEAD_BEEF; m_req_size = 2'b10;
        tick();
        m_req_write = 0;
        tick();
        m_req_valid = 0;
        tick(); tick();
        mem_data_out = 32'hDEAD_BEEF;
        tick(); tick();

        // Contention: four data writes win, fetch forced on the fifth.
        f_req_valid = 1; f_req_addr = 32'h0100_0008;
        m_req_valid = 1; m_req_write = 1; m_req_addr = 32'h0000_0200; m_req_wdata = 32'h1234_5678;
        repeat (5) tick();
        f_req_valid = 0;
        repeat (4) tick();
        m_req_valid = 0;
        tick();

        // Flush one cycle after accept.
        f_req_valid = 1; f_req_addr = 32'h0100_0010;
        tick();
        f_req_valid = 0; f_flush = 1;
        tick();
        f_flush = 0;
        tick(); tick();
        // Next fetch accepted with flush in the same cycle.
        f_req_valid = 1; f_req_addr = 32'h0100_0014; f_flush = 1;
        tick();
        f_req_valid = 0; f_flush = 0;
        repeat (3) tick();
        f_req_valid = 1; f_req_addr = 32'h0100_0018;
        tick();
        f_req_valid = 0;
        repeat (3) tick();

        // Reset during an outstanding load aborts it.
        m_req_valid = 1; m_req_write = 0; m_req_addr = 32'h0000_0300;
        tick();
        m_req_valid = 0; reset = 1;
        tick();
        reset = 0;
        tick();
        m_req_valid = 1; m_req_addr = 32'h0000_0304;
        tick();
        m_req_valid = 0;
        repeat (3) tick();

        // Random traffic; requesters hold a request until the model grants it.
        for (int i = 0; i < 600; i++) begin
            if (!f_req_valid && $urandom_range(0, 2) == 0) begin
                f_req_valid = 1; f_req_addr = $urandom;
            end
            if (!m_req_valid && $urandom_range(0, 2) == 0) begin
                m_req_valid = 1; m_req_write = 1'($urandom_range(0, 1));
                m_req_addr = $urandom; m_req_wdata = $urandom; m_req_size = 2'($urandom_range(0, 2));
            end
            f_flush = ($urandom_range(0, 5) == 0);
            mem_data_out = $urandom;
            reset = ($urandom_range(0, 99) == 0);
            tick();
            if (exp_f_acc) f_req_valid = 0;
            if (exp_m_acc) m_req_valid = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
